// File: rtl/up_dwn_sweep_ctrl.sv
// Sweep controller for an external up/down counter.
// Drives the counter from wherever it sits to lo, then runs num_sweeps
// lo->hi->lo triangles and signals completion. Bounds and the sweep count
// are latched when a start is accepted, so the inputs may change while busy.
module up_dwn_sweep_ctrl #(
  parameter int CNT_WIDTH = 5,
  parameter int SWP_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_WIDTH-1:0] lo,
  input  logic [CNT_WIDTH-1:0] hi,
  input  logic [SWP_WIDTH-1:0] num_sweeps,
  input  logic [CNT_WIDTH-1:0] count,
  output logic                 en,
  output logic                 up_dn,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [SWP_WIDTH-1:0] sweep_cnt
);

  typedef enum logic [2:0] {IDLE, SEEK, UP, DOWN, FIN} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] lo_q, hi_q;
  logic [SWP_WIDTH-1:0] ns_q;

  logic                 at_lo, at_hi, more;
  logic [SWP_WIDTH:0]   sc_nxt;

  assign at_lo  = (count == lo_q);
  assign at_hi  = (count == hi_q);
  // One extra bit so the +1 can never wrap before the compare.
  assign sc_nxt = {1'b0, sweep_cnt} + {{SWP_WIDTH{1'b0}}, 1'b1};
  assign more   = (sc_nxt < {1'b0, ns_q});
  assign busy   = (state == SEEK) || (state == UP) || (state == DOWN);

  // Counter drive: turn-arounds at lo/hi reverse direction in the same cycle
  // so each bound is visited for exactly one cycle.
  always_comb begin
    en    = 1'b0;
    up_dn = 1'b0;
    case (state)
      SEEK: begin
        en    = 1'b1;
        up_dn = at_lo | (count < lo_q);
      end
      UP: begin
        en    = 1'b1;
        up_dn = ~at_hi;
      end
      DOWN: begin
        if (!at_lo) begin
          en = 1'b1;
        end else if (more) begin
          en    = 1'b1;
          up_dn = 1'b1;
        end
      end
      default: ;
    endcase
    // Reset and abort must freeze the counter in the very cycle they appear.
    if (!rst || (abort && busy)) en = 1'b0;
  end

  // Program sequencing, bound capture, sweep counting and status pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      lo_q      <= '0;
      hi_q      <= '0;
      ns_q      <= '0;
      sweep_cnt <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (lo < hi) begin
              lo_q      <= lo;
              hi_q      <= hi;
              ns_q      <= num_sweeps;
              sweep_cnt <= '0;
              if (num_sweeps == '0) begin
                state <= FIN;
                done  <= 1'b1;
              end else begin
                state <= SEEK;
              end
            end else begin
              err <= 1'b1;
            end
          end
        end
        SEEK: begin
          if (abort)      state <= IDLE;
          else if (at_lo) state <= UP;
        end
        UP: begin
          if (abort)      state <= IDLE;
          else if (at_hi) state <= DOWN;
        end
        DOWN: begin
          if (abort) begin
            state <= IDLE;
          end else if (at_lo) begin
            sweep_cnt <= sc_nxt[SWP_WIDTH-1:0];
            if (more) begin
              state <= UP;
            end else begin
              state <= FIN;
              done  <= 1'b1;
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/up_dwn_sweep_ctrl.md
UP_DWN_SWEEP_CTRL -- requirements
Module: up_dwn_sweep_ctrl

Interface
REQ-001 Parameter CNT_WIDTH, default 5, SHALL set the width of the counter value, lo, hi and count.
REQ-002 Parameter SWP_WIDTH, default 4, SHALL set the width of num_sweeps and sweep_cnt.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous, active-low; rst=0 at a rising edge SHALL reset the block.
REQ-005 Port start, input, 1 bit: request to begin a sweep program; sampled only in IDLE.
REQ-006 Port abort, input, 1 bit: terminate the running program.
REQ-007 Ports lo and hi, inputs, CNT_WIDTH bits each: sweep bounds; SHALL be captured at accepted start.
REQ-008 Port num_sweeps, input, SWP_WIDTH bits: number of full lo->hi->lo sweeps; SHALL be captured at accepted start.
REQ-009 Port count, input, CNT_WIDTH bits: feedback from the up_dwn counter being controlled.
REQ-010 Port en, output, 1 bit: counter enable.
REQ-011 Port up_dn, output, 1 bit: counter direction (1 = up, 0 = down).
REQ-012 Port busy, output, 1 bit: high in SEEK, UP and DOWN.
REQ-013 Port done, output, 1 bit: one-cycle pulse on normal completion.
REQ-014 Port err, output, 1 bit: one-cycle pulse on a rejected start.
REQ-015 Port sweep_cnt, output, SWP_WIDTH bits: number of completed sweeps in the current or last program.

Function
REQ-016 Counter model: when en=1, count SHALL change by +1 (up_dn=1) or -1 (up_dn=0) one clock after the edge; the controller SHALL never rely on wrap-around.
REQ-017 States SHALL be IDLE, SEEK, UP, DOWN and FIN; en and up_dn SHALL be combinational from the state, the captured bounds and count.
REQ-018 IDLE: en=0, up_dn=0. A start with lo<hi SHALL capture the inputs, clear sweep_cnt and go to SEEK.
REQ-019 IDLE: a start with lo>=hi SHALL pulse err for one cycle next cycle and stay in IDLE.
REQ-020 IDLE: a start with lo<hi and num_sweeps=0 SHALL go directly to FIN without enabling the counter.
REQ-021 SEEK: while count!=lo, en SHALL be 1 and up_dn SHALL be (count<lo); when count==lo, en=1, up_dn=1 and the next state SHALL be UP.
REQ-022 UP: while count!=hi, en=1 and up_dn=1; when count==hi, en=1, up_dn=0 and the next state SHALL be DOWN, so that hi is held for exactly one cycle.
REQ-023 DOWN: while count!=lo, en=1 and up_dn=0; when count==lo, sweep_cnt SHALL increment.
REQ-024 DOWN, count==lo and sweep_cnt+1<num_sweeps: en=1, up_dn=1 and the next state SHALL be UP.
REQ-025 DOWN, count==lo and the final sweep: en=0 and the next state SHALL be FIN.
REQ-026 FIN: en=0 and done=1 for one cycle; the next state SHALL be IDLE.
REQ-027 The resulting steady-state count sequence SHALL be lo, lo+1..hi, hi-1..lo, repeated num_sweeps times. Each sweep SHALL take 2*(hi-lo) cycles, plus 1 final cycle with count==lo.
REQ-028 start while busy SHALL be ignored; lo, hi and num_sweeps changes while busy SHALL have no effect.
REQ-029 abort in SEEK, UP or DOWN SHALL force en=0 in the same cycle and go to IDLE at the next edge; done SHALL NOT pulse, and sweep_cnt SHALL hold its value.
REQ-030 abort and start asserted together in IDLE: start SHALL take priority, and abort SHALL be ignored outside SEEK, UP and DOWN.

Reset
REQ-031 While rst=0, en SHALL be forced to 0 combinationally.
REQ-032 At a rising edge with rst=0: state=IDLE, up_dn=0, busy=0, done=0, err=0, sweep_cnt=0, and captured lo, hi and num_sweeps=0.
REQ-033 Reset mid-program SHALL abandon the program without a done pulse; after rst returns to 1, the block SHALL accept start on the first cycle.

Verification
REQ-034 Bench SHALL cover each scenario below, with the controller closed-loop on an up_dwn counter (CNT_WIDTH=5) starting at 0:
- lo=3, hi=6, num_sweeps=2, start -> count 0,1,2,3,4,5,6,5,4,3,4,5,6,5,4,3; done 1 cycle after the final 3; sweep_cnt=2; en low afterwards.
- count=10, lo=2, hi=5, num_sweeps=1 -> SEEK counts down 10..2, then 3,4,5,4,3,2; done pulses.
- lo=7, hi=7, start -> err pulse 1 cycle, busy stays 0, en stays 0; lo=9, hi=4 -> same.
- lo=0, hi=31, num_sweeps=1 -> count reaches 31 then descends; no wrap to 0 after 31.
- abort when count=5 in UP -> en=0 that cycle, count frozen at 5, no done, sweep_cnt unchanged; a new start is accepted the next cycle.
- rst=0 asserted mid-DOWN -> en=0 immediately, all outputs at reset values after the edge; num_sweeps=0 start -> done next cycle, en never 1.
